r200_fwd_scoreboard: RTL
========================

Name: r200_fwd_scoreboard

Overview:
Parametrised operand-forwarding and interlock unit for the r200 pipeline family. It generalises the fixed EX/MEM/WB bypass to NSTAGES post-decode stages with a configurable load-data stage. It keeps an internal in-flight destination scoreboard that shifts with the pipeline, resolves both decode-stage source operands, inserts load-use bubbles and handles branch flush. It sits beside decode and drives the ID/EX operand inputs and stall.

Parameters:
XLEN, 32, datapath width
NSTAGES, 3, post-decode stages able to forward (stage 0 = EX, NSTAGES-1 = WB); range 2..8
LD_STAGE, 2, first stage index where load data is valid on st_data; range 1..NSTAGES-1
CNTW, 16, width of saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  decode slot holds a real instruction
id_rs1  in  5  source 1 address
id_rs2  in  5  source 2 address
id_use1  in  1  instruction reads rs1
id_use2  in  1  instruction reads rs2
id_rd  in  5  destination address
id_regwr  in  1  instruction writes rd
id_isload  in  1  rd written from data memory
rf_rs1o  in  XLEN  register-file value for rs1
rf_rs2o  in  XLEN  register-file value for rs2
st_data  in  NSTAGES*XLEN  per-stage result bus; slice k = [k*XLEN +: XLEN]
flush  in  1  branch/jump taken in EX; kill the decode instruction
op1  out  XLEN  forwarded rs1 value
op2  out  XLEN  forwarded rs2 value
fwd_sel1  out  4  0 = register file, k+1 = stage k
fwd_sel2  out  4  as fwd_sel1 for rs2
stall  out  1  hold IF/ID and PC; bubble into EX
stall_cnt  out  CNTW  cycles with stall=1, saturating

Behaviour:
- Clock: one clock, clk. Reset: rst is synchronous and active-high.
- Scoreboard: NSTAGES entries {v, rd[4:0], wr, ld}, each entry k tracking the instruction in stage k.
- Each clock, entries shift from k to k+1. Entry NSTAGES-1 is discarded.
- Entry 0 is loaded with {id_valid & ~stall & ~flush, id_rd, id_regwr, id_isload}.
- Shift continues during stall. Only the decode slot holds.
- Match for source s (rs = id_rs1 or id_rs2): v & wr & rd==rs & rs!=0 & id_use_s & id_valid.
- If several entries match, the smallest k (youngest) wins.
- No match: sel=0, op = rf value.
- Match at k with ~ld or k>=LD_STAGE: sel=k+1, op = st_data slice k.
- Match at k with ld and k<LD_STAGE: load-use hazard. stall=1. sel/op are don't-care, so drive sel=0 and op = rf value.
- stall = hazard on either source, and is masked to 0 when flush=1. A flushed instruction never stalls.
- Stall length for back-to-back load->use is LD_STAGE cycles. With defaults, 2 bubbles; forwarding from stage 2 on the 3rd cycle.
- x0 never forwards or stalls, even if an entry has rd=0 and wr=1.
- op1, op2, fwd_sel1, fwd_sel2 and stall are combinational from the scoreboard and current inputs. There is no added latency.
- stall_cnt increments on every clock edge where stall=1. It saturates at 2^CNTW-1 and does not wrap.
- Priority on entry 0 load: rst > flush > stall > normal.
- Reset: all v=0 and stall_cnt=0. After reset, stall=0 and fwd_sel1=fwd_sel2=0 for any inputs, so op1/op2 = rf values.
- Reset mid-stall discards all in-flight entries. stall drops to 0 the cycle after reset.
- id_valid=0: no stall, no forwarding, bubble enters entry 0.
- Simultaneous flush and hazard: stall=0, bubble enters entry 0, counter does not increment.

Test Plan:
- Reset, then id_valid=1, rs1=5, rs2=6, no in-flight writes -> op1=rf_rs1o, op2=rf_rs2o, sel=0/0, stall=0.
- ALU write x5 (id_rd=5, regwr=1, isload=0) in cycle t, consumer rs1=5 in t+1 with st_data slice0=32'h1234 -> op1=32'h1234, fwd_sel1=1, stall=0. In t+2 (slice1=32'h1234) -> fwd_sel1=2.
- Load x7 in cycle t, consumer rs2=7 in t+1 -> stall=1 for t+1 and t+2. In t+3, fwd_sel2=3, op2 = slice2, stall=0, stall_cnt=2.
- Writes to x9 in consecutive cycles (values A then B), consumer rs1=9 -> fwd_sel1=1, op1 = slice0 (younger value B).
- Producer with rd=0, regwr=1, consumer rs1=0 -> fwd_sel1=0, op1=rf_rs1o. Same with id_use1=0 on a matching rs1 -> no forward, no stall.
- Load-use hazard with flush=1 in the same cycle -> stall=0, next-cycle entry 0 v=0, stall_cnt unchanged.
- Drive rst=1 during a load-use stall -> stall=0 next cycle.
- With CNTW=2, force 5 stall cycles -> stall_cnt=3 (saturated).

Source files
------------

// File: rtl/r200_fwd_scoreboard.sv
// r200 operand-forwarding and load-use interlock unit.
// Tracks in-flight destinations across NSTAGES post-decode stages and resolves both decode sources.
module r200_fwd_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NSTAGES  = 3,
   parameter int LD_STAGE = 2,
   parameter int CNTW     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [4:0]              id_rs1,
   input  logic [4:0]              id_rs2,
   input  logic                    id_use1,
   input  logic                    id_use2,
   input  logic [4:0]              id_rd,
   input  logic                    id_regwr,
   input  logic                    id_isload,
   input  logic [XLEN-1:0]         rf_rs1o,
   input  logic [XLEN-1:0]         rf_rs2o,
   input  logic [NSTAGES*XLEN-1:0] st_data,
   input  logic                    flush,
   output logic [XLEN-1:0]         op1,
   output logic [XLEN-1:0]         op2,
   output logic [3:0]              fwd_sel1,
   output logic [3:0]              fwd_sel2,
   output logic                    stall,
   output logic [CNTW-1:0]         stall_cnt
);

   logic [NSTAGES-1:0]      v_r;
   logic [NSTAGES-1:0]      wr_r;
   logic [NSTAGES-1:0]      ld_r;
   logic [NSTAGES-1:0][4:0] rd_r;
   logic [CNTW-1:0]         stall_cnt_r;

   logic [5:0]      look1_s;
   logic [5:0]      look2_s;
   logic            fwd1_s;
   logic            fwd2_s;
   logic            haz1_s;
   logic            haz2_s;
   logic            stall_s;
   logic [3:0]      sel1_s;
   logic [3:0]      sel2_s;
   logic [XLEN-1:0] op1_s;
   logic [XLEN-1:0] op2_s;

   // Returns {hit, load_use_hazard, stage_index}; scanning oldest to youngest lets the youngest match win.
   function automatic logic [5:0] lookup(
      input logic [4:0]              rs,
      input logic                    use_en,
      input logic                    valid,
      input logic [NSTAGES-1:0]      v,
      input logic [NSTAGES-1:0]      wr,
      input logic [NSTAGES-1:0]      ld,
      input logic [NSTAGES-1:0][4:0] rd
   );
      logic       hit;
      logic       haz;
      logic [3:0] idx;
      hit = 1'b0;
      haz = 1'b0;
      idx = 4'd0;
      for (int k = NSTAGES - 1; k >= 0; k--) begin
         if (v[k] && wr[k] && (rd[k] == rs) && (rs != 5'd0) && use_en && valid) begin
            hit = 1'b1;
            haz = ld[k] && (k < LD_STAGE);
            idx = 4'(k);
         end else begin
            hit = hit;
            haz = haz;
            idx = idx;
         end
      end
      return {hit, haz, idx};
   endfunction

   function automatic logic [XLEN-1:0] stage_val(
      input logic [NSTAGES*XLEN-1:0] bus,
      input logic [3:0]              idx
   );
      logic [XLEN-1:0] val;
      val = '0;
      for (int k = 0; k < NSTAGES; k++) begin
         if (idx == 4'(k)) begin
            val = bus[k*XLEN +: XLEN];
         end else begin
            val = val;
         end
      end
      return val;
   endfunction

   // Operand resolution and interlock; a load still short of LD_STAGE blocks forwarding and falls back to the RF.
   always_comb begin
      look1_s = lookup(id_rs1, id_use1, id_valid, v_r, wr_r, ld_r, rd_r);
      look2_s = lookup(id_rs2, id_use2, id_valid, v_r, wr_r, ld_r, rd_r);
      haz1_s  = look1_s[5] & look1_s[4];
      haz2_s  = look2_s[5] & look2_s[4];
      fwd1_s  = look1_s[5] & ~look1_s[4];
      fwd2_s  = look2_s[5] & ~look2_s[4];
      stall_s = (haz1_s | haz2_s) & ~flush;
      if (fwd1_s) begin
         sel1_s = look1_s[3:0] + 4'd1;
         op1_s  = stage_val(st_data, look1_s[3:0]);
      end else begin
         sel1_s = 4'd0;
         op1_s  = rf_rs1o;
      end
      if (fwd2_s) begin
         sel2_s = look2_s[3:0] + 4'd1;
         op2_s  = stage_val(st_data, look2_s[3:0]);
      end else begin
         sel2_s = 4'd0;
         op2_s  = rf_rs2o;
      end
   end

   // Scoreboard shifts every cycle, even under stall; entry 0 takes the decode instruction unless flushed or stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_r         <= '0;
         wr_r        <= '0;
         ld_r        <= '0;
         rd_r        <= '0;
         stall_cnt_r <= '0;
      end else begin
         v_r  <= {v_r[NSTAGES-2:0], id_valid & ~stall_s & ~flush};
         wr_r <= {wr_r[NSTAGES-2:0], id_regwr};
         ld_r <= {ld_r[NSTAGES-2:0], id_isload};
         rd_r <= {rd_r[NSTAGES-2:0], id_rd};
         if (stall_s && (stall_cnt_r != {CNTW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNTW'(1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign op1       = op1_s;
   assign op2       = op2_s;
   assign fwd_sel1  = sel1_s;
   assign fwd_sel2  = sel2_s;
   assign stall     = stall_s;
   assign stall_cnt = stall_cnt_r;

endmodule
